// File: rtl/cpu_loader_pkg.sv
// Shared types for the CPU memory loader: FSM states, byte-address shifts
// and the phase-ordering rule used to pick the next non-empty phase.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_IMEM,
    ST_WR_DMEM,
    ST_VERIFY,
    ST_RUN,
    ST_DUMP,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int IMEM_BYTE_SHIFT = 2;
  localparam int DMEM_BYTE_SHIFT = 3;

  // Next phase after 'cur' finishes, skipping phases with no work.
  // IDLE/DONE/ERROR stand for "start accepted".
  function automatic state_e next_stage(input state_e cur, input logic has_i,
                                        input logic has_d, input logic has_r);
    state_e nxt;
    case (cur)
      ST_IDLE, ST_DONE, ST_ERROR:
        nxt = has_i ? ST_WR_IMEM : has_d ? ST_WR_DMEM : has_r ? ST_RUN : ST_DONE;
      ST_WR_IMEM: nxt = has_d ? ST_WR_DMEM : ST_VERIFY;
      ST_WR_DMEM: nxt = has_i ? ST_VERIFY : has_r ? ST_RUN : ST_DUMP;
      ST_VERIFY:  nxt = has_r ? ST_RUN : has_d ? ST_DUMP : ST_DONE;
      ST_RUN:     nxt = has_d ? ST_DUMP : ST_DONE;
      default:    nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/loader_rd_skid.sv
// One-entry valid/ready output register fed by a memory with one-cycle read
// latency; allows at most one read in flight.
module loader_rd_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         req_avail,
  input  logic [W-1:0] rdata,
  input  logic         m_ready,
  output logic         rd_issue,
  output logic         rd_pend,
  output logic         m_valid,
  output logic [W-1:0] m_data
);

  logic         pend_q, pend_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Issue only when the slot is free (or draining now) so the returning
  // word always lands in an empty register.
  assign rd_issue = req_avail && !pend_q && (!valid_q || m_ready);
  assign rd_pend  = pend_q;
  assign m_valid  = valid_q;
  assign m_data   = data_q;

  always_comb begin
    pend_d  = rd_issue;
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && m_ready) valid_d = 1'b0;
    if (pend_q) begin
      valid_d = 1'b1;
      data_d  = rdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cpu_mem_loader.sv
// Loads a program image into imem/dmem from a word stream, verifies imem by
// XOR readback, runs the CPU for a fixed cycle count and dumps dmem.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [IMEM_ADDR_W:0] imem_count,
  input  logic [DMEM_ADDR_W:0] dmem_count,
  input  logic [31:0]          run_cycles,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [63:0]          s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [63:0]          m_data,
  output logic [63:0]          addr_ext,
  output logic                 wen_ext,
  output logic                 ren_ext,
  output logic [31:0]          wdata_ext,
  input  logic [31:0]          rdata_ext,
  output logic [63:0]          addr_ext_2,
  output logic                 wen_ext_2,
  output logic                 ren_ext_2,
  output logic [63:0]          wdata_ext_2,
  input  logic [63:0]          rdata_ext_2,
  output logic                 cpu_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int IDX_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;
  localparam logic [IMEM_ADDR_W:0] IMEM_DEPTH = {1'b1, {IMEM_ADDR_W{1'b0}}};
  localparam logic [DMEM_ADDR_W:0] DMEM_DEPTH = {1'b1, {DMEM_ADDR_W{1'b0}}};

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
  logic [IMEM_ADDR_W:0] icnt_q, icnt_d, icnt_clip;
  logic [DMEM_ADDR_W:0] dcnt_q, dcnt_d, dcnt_clip;
  logic [31:0]          run_q, run_d;
  logic [31:0]          csum_q, csum_d;
  logic [31:0]          rdbk_q, rdbk_d;
  logic                 vpend_q, vpend_d;
  logic                 has_i, has_d, has_r;
  logic                 i_last, d_last, dump_avail, rd_issue, rd_pend;

  assign icnt_clip  = (imem_count > IMEM_DEPTH) ? IMEM_DEPTH : imem_count;
  assign dcnt_clip  = (dmem_count > DMEM_DEPTH) ? DMEM_DEPTH : dmem_count;
  assign has_i      = (icnt_q != '0);
  assign has_d      = (dcnt_q != '0);
  assign has_r      = (run_q != '0);
  assign idx_inc    = idx_q + IDX_W'(1);
  assign i_last     = (idx_inc == IDX_W'(icnt_q));
  assign d_last     = (idx_inc == IDX_W'(dcnt_q));
  assign dump_avail = (state_q == ST_DUMP) && (idx_q != IDX_W'(dcnt_q));

  assign busy  = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done  = (state_q == ST_DONE);
  assign error = (state_q == ST_ERROR);

  loader_rd_skid #(.W(64)) u_skid (
    .clk       (clk),
    .arst      (arst),
    .req_avail (dump_avail),
    .rdata     (rdata_ext_2),
    .m_ready   (m_ready),
    .rd_issue  (rd_issue),
    .rd_pend   (rd_pend),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    icnt_d      = icnt_q;
    dcnt_d      = dcnt_q;
    run_d       = run_q;
    csum_d      = csum_q;
    rdbk_d      = rdbk_q;
    vpend_d     = vpend_q;
    s_ready     = 1'b0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    addr_ext    = '0;
    wdata_ext   = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    addr_ext_2  = '0;
    wdata_ext_2 = '0;
    cpu_enable  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          icnt_d  = icnt_clip;
          dcnt_d  = dcnt_clip;
          run_d   = run_cycles;
          idx_d   = '0;
          csum_d  = '0;
          rdbk_d  = '0;
          vpend_d = 1'b0;
          state_d = next_stage(state_q, icnt_clip != '0, dcnt_clip != '0, run_cycles != '0);
        end
      end
      ST_WR_IMEM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wen_ext   = 1'b1;
          addr_ext  = 64'(idx_q) << IMEM_BYTE_SHIFT;
          wdata_ext = s_data[31:0];
          csum_d    = csum_q ^ s_data[31:0];
          idx_d     = idx_inc;
          if (i_last) begin
            idx_d   = '0;
            state_d = next_stage(ST_WR_IMEM, has_i, has_d, has_r);
          end
        end
      end
      ST_WR_DMEM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wen_ext_2   = 1'b1;
          addr_ext_2  = 64'(idx_q) << DMEM_BYTE_SHIFT;
          wdata_ext_2 = s_data;
          idx_d       = idx_inc;
          if (d_last) begin
            idx_d   = '0;
            state_d = next_stage(ST_WR_DMEM, has_i, has_d, has_r);
          end
        end
      end
      ST_VERIFY: begin
        // Reads are pipelined; vpend_q marks that rdata_ext holds a word now.
        vpend_d = 1'b0;
        if (vpend_q) rdbk_d = rdbk_q ^ rdata_ext;
        if (idx_q != IDX_W'(icnt_q)) begin
          ren_ext  = 1'b1;
          addr_ext = 64'(idx_q) << IMEM_BYTE_SHIFT;
          idx_d    = idx_inc;
          vpend_d  = 1'b1;
        end else if (vpend_q) begin
          idx_d   = '0;
          state_d = (rdbk_d == csum_q) ? next_stage(ST_VERIFY, has_i, has_d, has_r) : ST_ERROR;
        end
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        run_d      = run_q - 32'd1;
        if (run_q == 32'd1) state_d = next_stage(ST_RUN, has_i, has_d, has_r);
      end
      ST_DUMP: begin
        if (rd_issue) begin
          ren_ext_2  = 1'b1;
          addr_ext_2 = 64'(idx_q) << DMEM_BYTE_SHIFT;
          idx_d      = idx_inc;
        end
        if (!dump_avail && !rd_pend && m_valid && m_ready) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      run_q   <= '0;
      csum_q  <= '0;
      rdbk_q  <= '0;
      vpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      run_q   <= run_d;
      csum_q  <= csum_d;
      rdbk_q  <= rdbk_d;
      vpend_q <= vpend_d;
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: memory models on both ext ports, a bus monitor,
// and per-feature scenarios checked against a plain-arithmetic job model.
module tb_cpu_mem_loader;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  imem_count = '0;
  logic [10:0] dmem_count = '0;
  logic [31:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        cpu_enable, busy, done, error;

  cpu_mem_loader dut (
    .clk(clk), .arst(arst), .start(start), .imem_count(imem_count),
    .dmem_count(dmem_count), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  wire [297:0] outs = {s_ready, m_valid, m_data, addr_ext, wen_ext, ren_ext, wdata_ext,
                       addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
                       cpu_enable, busy, done, error};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- memory models ----------------
  logic [31:0] imem_m [0:511];
  logic [63:0] dmem_m [0:1023];
  logic        corrupt_en = 1'b0;
  logic [63:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (wen_ext) imem_m[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= (corrupt_en && addr_ext == corrupt_addr) ? 32'h0 : imem_m[addr_ext[10:2]];
    if (wen_ext_2) dmem_m[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem_m[addr_ext_2[12:3]];
  end

  // ---------------- bus monitor ----------------
  logic [63:0] iw_a[$], dw_a[$], dw_d[$], dump_q[$];
  logic [31:0] iw_d[$];
  int ird_n = 0, drd_n = 0, en_n = 0, en_bursts = 0;
  int excl_v = 0, zero_v = 0, runstrobe_v = 0, stab_v = 0;
  logic        prev_en = 1'b0, prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    if (arst) begin
      prev_en = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (wen_ext) begin iw_a.push_back(addr_ext); iw_d.push_back(wdata_ext); end
      if (wen_ext_2) begin dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2); end
      if (ren_ext) ird_n++;
      if (ren_ext_2) drd_n++;
      if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) excl_v++;
      if (!wen_ext && wdata_ext != 0) zero_v++;
      if (!wen_ext && !ren_ext && addr_ext != 0) zero_v++;
      if (!wen_ext_2 && wdata_ext_2 != 0) zero_v++;
      if (!wen_ext_2 && !ren_ext_2 && addr_ext_2 != 0) zero_v++;
      if (cpu_enable) begin
        en_n++;
        if (!prev_en) en_bursts++;
        if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) runstrobe_v++;
      end
      prev_en = cpu_enable;
      if (prev_hold && (!m_valid || m_data != prev_data)) stab_v++;
      if (m_valid && m_ready) dump_q.push_back(m_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] words_i[$];
  logic [63:0] words_d[$];

  // Verify fails iff the XOR of what comes back differs from the XOR written.
  function automatic bit model_err(int n, bit corrupt_second);
    logic [31:0] w, r;
    w = '0;
    r = '0;
    for (int k = 0; k < n; k++) begin
      w ^= words_i[k];
      r ^= (corrupt_second && k == 1) ? 32'h0 : words_i[k];
    end
    return (n > 0) && (w != r);
  endfunction

  function automatic int clip(int n, int depth);
    return (n > depth) ? depth : n;
  endfunction

  // ---------------- driver tasks ----------------
  int b_iw, b_dw, b_dump, b_ird, b_drd, b_en, b_burst, b_ex, b_zv, b_rs, b_st;
  int job_cycles;
  logic done_after_start;

  task automatic send_word(input logic [63:0] w, input bit gap);
    int  wait_n;
    bit  hs;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    wait_n  = 0;
    hs      = 1'b0;
    while (!hs && wait_n < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      wait_n++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    n_checks++;
    if (!hs) begin
      n_fail++;
      $display("FAIL stream_accept: word %h got s_ready=%0b, required 1 within 200 cycles", w, s_ready);
    end
  endtask

  task automatic do_job(input int ic, input int dc, input int rc, input bit gaps,
                        input int hold_low, input bit rnd_ready);
    int icl, dcl, cyc, low_used;
    b_iw = iw_a.size(); b_dw = dw_a.size(); b_dump = dump_q.size();
    b_ird = ird_n; b_drd = drd_n; b_en = en_n; b_burst = en_bursts;
    b_ex = excl_v; b_zv = zero_v; b_rs = runstrobe_v; b_st = stab_v;
    icl = clip(ic, 512);
    dcl = clip(dc, 1024);
    imem_count = 10'(ic);
    dmem_count = 11'(dc);
    run_cycles = 32'(rc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_after_start = done;
    for (int k = 0; k < icl; k++) send_word({32'($urandom), words_i[k]}, gaps && (k % 2 == 1));
    for (int k = 0; k < dcl; k++) send_word(words_d[k], gaps && (k % 2 == 1));
    cyc = 0;
    low_used = 0;
    while (!(done || error) && cyc < 4000) begin
      if (m_valid && low_used < hold_low) begin
        m_ready = 1'b0;
        low_used++;
      end else begin
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    job_cycles = cyc;
    n_checks++;
    if (!(done || error)) begin
      n_fail++;
      $display("FAIL job_timeout: done=%0b error=%0b after %0d cycles, required done or error", done, error, cyc);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_hold: outputs %h, required 0", outs); end
    arst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_release: outputs %h, required 0", outs); end
  endtask

  task automatic test_load_path;
    words_i = {};
    words_d = {};
    words_i.push_back(32'h00000013); words_i.push_back(32'h00100093); words_i.push_back(32'h00208133);
    words_d.push_back(64'hDEADBEEF_00000001); words_d.push_back(64'h2);
    do_job(3, 2, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL load_status: done=%0b error=%0b, required 1/0", done, error); end
    n_checks++;
    if (iw_a.size() - b_iw != 3) begin n_fail++; $display("FAIL load_imem_count: %0d writes, required 3", iw_a.size() - b_iw); end
    for (int k = 0; k < 3 && b_iw + k < iw_a.size(); k++) begin
      n_checks++;
      if (iw_a[b_iw+k] !== 64'(k * 4) || iw_d[b_iw+k] !== words_i[k]) begin
        n_fail++;
        $display("FAIL load_imem_wr[%0d]: addr %h data %h, required addr %h data %h", k, iw_a[b_iw+k], iw_d[b_iw+k], k * 4, words_i[k]);
      end
    end
    n_checks++;
    if (dw_a.size() - b_dw != 2) begin n_fail++; $display("FAIL load_dmem_count: %0d writes, required 2", dw_a.size() - b_dw); end
    for (int k = 0; k < 2 && b_dw + k < dw_a.size(); k++) begin
      n_checks++;
      if (dw_a[b_dw+k] !== 64'(k * 8) || dw_d[b_dw+k] !== words_d[k]) begin
        n_fail++;
        $display("FAIL load_dmem_wr[%0d]: addr %h data %h, required addr %h data %h", k, dw_a[b_dw+k], dw_d[b_dw+k], k * 8, words_d[k]);
      end
    end
    n_checks++;
    if (ird_n - b_ird != 3) begin n_fail++; $display("FAIL load_verify_reads: %0d, required 3", ird_n - b_ird); end
    n_checks++;
    if (dump_q.size() - b_dump != 2) begin n_fail++; $display("FAIL load_dump_count: %0d, required 2", dump_q.size() - b_dump); end
    for (int k = 0; k < 2 && b_dump + k < dump_q.size(); k++) begin
      n_checks++;
      if (dump_q[b_dump+k] !== words_d[k]) begin
        n_fail++;
        $display("FAIL load_dump[%0d]: %h, required %h", k, dump_q[b_dump+k], words_d[k]);
      end
    end
    n_checks++;
    if (en_n != b_en || excl_v != b_ex || zero_v != b_zv) begin
      n_fail++;
      $display("FAIL load_bus_rules: enable cycles %0d, exclusivity hits %0d, nonzero-idle hits %0d, required 0/0/0", en_n - b_en, excl_v - b_ex, zero_v - b_zv);
    end
  endtask

  task automatic test_verify_fail;
    bit exp_err;
    corrupt_en = 1'b1;
    corrupt_addr = 64'd4;
    exp_err = model_err(3, 1'b1);
    do_job(3, 2, 5, 1'b0, 0, 1'b0);
    corrupt_en = 1'b0;
    n_checks++;
    if ({done, error} !== {!exp_err, exp_err}) begin
      n_fail++;
      $display("FAIL verify_status: done=%0b error=%0b, required %0b/%0b", done, error, !exp_err, exp_err);
    end
    n_checks++;
    if (en_n - b_en != 0) begin n_fail++; $display("FAIL verify_no_run: %0d enable cycles, required 0", en_n - b_en); end
    n_checks++;
    if (drd_n - b_drd != 0 || dump_q.size() - b_dump != 0) begin
      n_fail++;
      $display("FAIL verify_no_dump: %0d dmem reads %0d dumped, required 0/0", drd_n - b_drd, dump_q.size() - b_dump);
    end
  endtask

  task automatic test_run_length;
    words_i = {};
    words_d = {};
    for (int k = 0; k < 2; k++) words_i.push_back($urandom);
    do_job(2, 0, 5, 1'b0, 0, 1'b0);
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL run_status: done=%0b error=%0b, required 1/0", done, error); end
    n_checks++;
    if (en_n - b_en != 5) begin n_fail++; $display("FAIL run_cycles: %0d enable cycles, required 5", en_n - b_en); end
    n_checks++;
    if (en_bursts - b_burst != 1) begin n_fail++; $display("FAIL run_contiguous: %0d bursts, required 1", en_bursts - b_burst); end
    n_checks++;
    if (runstrobe_v - b_rs != 0) begin n_fail++; $display("FAIL run_no_strobes: %0d strobe cycles, required 0", runstrobe_v - b_rs); end
  endtask

  task automatic test_backpressure;
    words_i = {};
    words_d = {};
    for (int k = 0; k < 4; k++) words_i.push_back($urandom);
    for (int k = 0; k < 3; k++) words_d.push_back({$urandom, $urandom});
    do_job(4, 3, 0, 1'b1, 4, 1'b0);
    n_checks++;
    if (iw_a.size() - b_iw != 4 || dw_a.size() - b_dw != 3) begin
      n_fail++;
      $display("FAIL bp_write_counts: imem %0d dmem %0d, required 4/3", iw_a.size() - b_iw, dw_a.size() - b_dw);
    end
    for (int k = 0; k < 4 && b_iw + k < iw_a.size(); k++) begin
      n_checks++;
      if (iw_a[b_iw+k] !== 64'(k * 4) || iw_d[b_iw+k] !== words_i[k]) begin
        n_fail++;
        $display("FAIL bp_imem_wr[%0d]: addr %h data %h, required addr %h data %h", k, iw_a[b_iw+k], iw_d[b_iw+k], k * 4, words_i[k]);
      end
    end
    n_checks++;
    if (dump_q.size() - b_dump != 3) begin n_fail++; $display("FAIL bp_dump_count: %0d, required 3", dump_q.size() - b_dump); end
    for (int k = 0; k < 3 && b_dump + k < dump_q.size(); k++) begin
      n_checks++;
      if (dump_q[b_dump+k] !== words_d[k]) begin
        n_fail++;
        $display("FAIL bp_dump[%0d]: %h, required %h", k, dump_q[b_dump+k], words_d[k]);
      end
    end
    n_checks++;
    if (stab_v - b_st != 0) begin n_fail++; $display("FAIL bp_m_stable: %0d unstable cycles, required 0", stab_v - b_st); end
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL bp_status: done=%0b error=%0b, required 1/0", done, error); end
  endtask

  task automatic test_zero_counts;
    do_job(0, 0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (done !== 1'b1 || job_cycles > 2) begin
      n_fail++;
      $display("FAIL zero_done: done=%0b after %0d extra cycles, required 1 within 2", done, job_cycles);
    end
    n_checks++;
    if ((iw_a.size() - b_iw) + (dw_a.size() - b_dw) + (ird_n - b_ird) + (drd_n - b_drd) != 0) begin
      n_fail++;
      $display("FAIL zero_no_strobes: %0d strobes seen, required 0",
               (iw_a.size() - b_iw) + (dw_a.size() - b_dw) + (ird_n - b_ird) + (drd_n - b_drd));
    end
  endtask

  task automatic test_reset_mid_load;
    imem_count = 10'd4;
    dmem_count = '0;
    run_cycles = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(64'h0000_0000_1111_1111, 1'b0);
    arst = 1'b1;
    #1;
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs: %h, required 0", outs); end
    @(posedge clk); #1;
    arst = 1'b0;
    words_i = {};
    words_d = {};
    for (int k = 0; k < 4; k++) words_i.push_back($urandom);
    do_job(4, 0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (iw_a.size() - b_iw != 4) begin n_fail++; $display("FAIL midreset_reload_count: %0d, required 4", iw_a.size() - b_iw); end
    for (int k = 0; k < 4 && b_iw + k < iw_a.size(); k++) begin
      n_checks++;
      if (iw_a[b_iw+k] !== 64'(k * 4)) begin
        n_fail++;
        $display("FAIL midreset_reload_addr[%0d]: %h, required %h", k, iw_a[b_iw+k], k * 4);
      end
    end
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL midreset_status: done=%0b error=%0b, required 1/0", done, error); end
  endtask

  task automatic test_clip;
    words_i = {};
    words_d = {};
    for (int k = 0; k < 512; k++) words_i.push_back($urandom);
    do_job(1023, 0, 0, 1'b0, 0, 1'b0);
    n_checks++;
    if (iw_a.size() - b_iw != 512) begin n_fail++; $display("FAIL clip_count: %0d writes, required 512", iw_a.size() - b_iw); end
    n_checks++;
    if (iw_a.size() > 0 && iw_a[iw_a.size()-1] !== 64'h7FC) begin
      n_fail++;
      $display("FAIL clip_last_addr: %h, required 7fc", iw_a[iw_a.size()-1]);
    end
    n_checks++;
    if (ird_n - b_ird != 512) begin n_fail++; $display("FAIL clip_reads: %0d, required 512", ird_n - b_ird); end
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL clip_status: done=%0b error=%0b, required 1/0", done, error); end
  endtask

  task automatic test_back_to_back;
    int ic, dc, rc;
    bit exp_err, exp_done_at_start;
    for (int it = 0; it < 8; it++) begin
      ic = $urandom_range(0, 6);
      dc = $urandom_range(0, 5);
      rc = $urandom_range(0, 6);
      words_i = {};
      words_d = {};
      for (int k = 0; k < ic; k++) words_i.push_back($urandom);
      for (int k = 0; k < dc; k++) words_d.push_back({$urandom, $urandom});
      exp_err = model_err(ic, 1'b0);
      exp_done_at_start = (ic == 0 && dc == 0 && rc == 0);
      do_job(ic, dc, rc, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
      n_checks++;
      if (done_after_start !== exp_done_at_start) begin
        n_fail++;
        $display("FAIL b2b_done_clear[%0d]: done=%0b after start, required %0b", it, done_after_start, exp_done_at_start);
      end
      n_checks++;
      if ({done, error} !== {!exp_err, exp_err}) begin
        n_fail++;
        $display("FAIL b2b_status[%0d]: done=%0b error=%0b, required %0b/%0b", it, done, error, !exp_err, exp_err);
      end
      n_checks++;
      if (iw_a.size() - b_iw != ic || dw_a.size() - b_dw != dc || en_n - b_en != rc) begin
        n_fail++;
        $display("FAIL b2b_counts[%0d]: imem %0d dmem %0d run %0d, required %0d/%0d/%0d", it,
                 iw_a.size() - b_iw, dw_a.size() - b_dw, en_n - b_en, ic, dc, rc);
      end
      n_checks++;
      if (dump_q.size() - b_dump != dc) begin n_fail++; $display("FAIL b2b_dump_count[%0d]: %0d, required %0d", it, dump_q.size() - b_dump, dc); end
      for (int k = 0; k < dc && b_dump + k < dump_q.size(); k++) begin
        n_checks++;
        if (dump_q[b_dump+k] !== words_d[k]) begin
          n_fail++;
          $display("FAIL b2b_dump[%0d][%0d]: %h, required %h", it, k, dump_q[b_dump+k], words_d[k]);
        end
      end
      n_checks++;
      if (excl_v != b_ex || zero_v != b_zv || runstrobe_v != b_rs || stab_v != b_st) begin
        n_fail++;
        $display("FAIL b2b_bus_rules[%0d]: excl %0d idle %0d runstrobe %0d unstable %0d, required all 0", it,
                 excl_v - b_ex, zero_v - b_zv, runstrobe_v - b_rs, stab_v - b_st);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_load_path;
    test_verify_fail;
    test_run_length;
    test_backpressure;
    test_zero_counts;
    test_reset_mid_load;
    test_clip;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
Host-side initiator for the CPU's external memory ports. It takes a program image as a valid/ready word stream and writes it into instruction memory and data memory. It then reads instruction memory back to check it, runs the CPU for a fixed number of cycles, and streams the final data memory contents back out. It sits between the testbench/host interface and the cpu top, driving addr_ext*/wen_ext*/ren_ext*/wdata_ext* and enable.

Parameters:
IMEM_ADDR_W, 9, log2 of instruction-memory depth in 32-bit words
DMEM_ADDR_W, 10, log2 of data-memory depth in 64-bit words

Ports:
clk  in  1  system clock, all logic rising-edge
arst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; accepted only in IDLE, DONE or ERROR
imem_count  in  IMEM_ADDR_W+1  instruction words to load, sampled at start
dmem_count  in  DMEM_ADDR_W+1  data words to load and later dump, sampled at start
run_cycles  in  32  cycles to hold cpu_enable, sampled at start
s_valid  in  1  input stream word valid
s_ready  out  1  input stream ready
s_data  in  64  input word; imem phase uses [31:0]
m_valid  out  1  dump stream valid
m_ready  in  1  dump stream ready
m_data  out  64  dumped data-memory word
addr_ext  out  64  imem byte address
wen_ext  out  1  imem write enable
ren_ext  out  1  imem read enable
wdata_ext  out  32  imem write data
rdata_ext  in  32  imem read data, valid the cycle after ren_ext
addr_ext_2  out  64  dmem byte address
wen_ext_2  out  1  dmem write enable
ren_ext_2  out  1  dmem read enable
wdata_ext_2  out  64  dmem write data
rdata_ext_2  in  64  dmem read data, valid the cycle after ren_ext_2
cpu_enable  out  1  drives cpu enable
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR

Behaviour:
- Reset state is IDLE. While arst is high, and after its release, all outputs are 0. Counters and checksum registers clear to 0.
- Reset asserted mid-operation aborts immediately. Partially written memory contents are left as they are.
- States: IDLE, WR_IMEM, WR_DMEM, VERIFY, RUN, DUMP, DONE, ERROR.
- On an accepted start, move to the first state whose work is non-zero, in this order: WR_IMEM (imem_count>0), WR_DMEM (dmem_count>0), RUN (run_cycles>0), DUMP (dmem_count>0), then DONE.
- VERIFY is entered after WR_DMEM, or directly after WR_IMEM when dmem_count=0. It is entered only if imem_count>0.
- WR_IMEM: s_ready=1. On each s_valid&s_ready, in the same cycle: wen_ext=1, addr_ext=i<<2, wdata_ext=s_data[31:0], checksum ^= s_data[31:0], i++. After word imem_count-1, advance.
- WR_DMEM: same handshake. wen_ext_2=1, addr_ext_2=j<<3, wdata_ext_2=s_data.
- s_ready is 0 in every other state.
- VERIFY: issue ren_ext for each word k in order (addr=k<<2), one read per cycle (pipelined). XOR each rdata_ext into a readback register on the following cycle.
- VERIFY completion: one cycle after the last read, compare readback with checksum. Equal goes to RUN/DUMP/DONE per the order above; unequal goes to ERROR.
- RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, then 0. No ext strobes are asserted during RUN.
- DUMP: at most one dmem read outstanding. Assert ren_ext_2 (addr=j<<3) only when the output register is empty, or is being drained this cycle.
- DUMP output: on the cycle after ren_ext_2, capture rdata_ext_2 into m_data and set m_valid. m_valid and m_data stay stable until m_ready. After the last word is accepted, go to DONE.
- wen_ext and ren_ext are never both high. Likewise wen_ext_2 and ren_ext_2. Address and data outputs are 0 whenever no strobe is active.
- The 64-bit addresses are zero-extended. Counts above memory depth are clipped to depth (2^IMEM_ADDR_W or 2^DMEM_ADDR_W).
- start in any busy state is ignored. start in DONE/ERROR begins a new load and clears done/error on the next cycle.

Decomposition:
- Shared package cpu_loader_pkg holds:
  - the state enum;
  - byte-shift constants IMEM_BYTE_SHIFT=2 and DMEM_BYTE_SHIFT=3.
- One sub-module is natural: loader_rd_skid, a 1-entry valid/ready output buffer with one-outstanding-read tracking, used by DUMP.

Test Plan:
- Load path: imem_count=3 {0x00000013,0x00100093,0x00208133}, dmem_count=2 {0xDEADBEEF_00000001,0x2}, run_cycles=0 -> imem writes at addr 0,4,8; dmem writes at 0,8; verify passes; dump returns both words in order; done=1.
- Verify failure: model forces rdata_ext=0x0 on the second read -> error=1, cpu_enable never asserted, no dump.
- Run length: run_cycles=5 -> cpu_enable high for exactly 5 cycles; no ext strobes in that window.
- Stream backpressure: s_valid toggled 1,0,1,0 on input and m_ready held low 4 cycles during dump -> no lost or duplicated writes; m_data stable while m_valid&!m_ready.
- Zero counts: imem_count=0, dmem_count=0, run_cycles=0 -> IDLE to DONE within 2 cycles, no strobes.
- Reset mid-load: arst pulsed during WR_IMEM after 1 of 4 words -> all outputs 0 immediately; a new start reloads from address 0.
